axi_mem_slave: RTL and testbench

- AXI4 responder (slave) with internal word-addressed RAM; the memory end of the cache's AXI master port.
- Used as synthesizable backing memory in cache and SoC testbenches and small FPGA builds.
- Independent read and write engines.
- One outstanding transaction per direction; no reordering.

---
 rtl/axi_mem_slave_if.sv | 53 +++++
 rtl/axi_mem_slave.sv | 209 ++++++++++++++++++++
 tb/tb_axi_mem_slave.sv | 618 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_slave_if.sv
// AXI4 bus bundle between a master (cache, testbench) and axi_mem_slave.
// Signal names follow the AXI channel naming used across the SoC.
interface axi_mem_slave_if;
    logic [3:0]  axi_awid;
    logic [31:0] axi_awaddr;
    logic [7:0]  axi_awlen;
    logic [2:0]  axi_awsize;
    logic [1:0]  axi_awburst;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wlast;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [3:0]  axi_bid;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;
    logic [3:0]  axi_arid;
    logic [31:0] axi_araddr;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [1:0]  axi_arburst;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [3:0]  axi_rid;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rlast;
    logic        axi_rvalid;
    logic        axi_rready;

    modport slave (
        input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst,
        input  axi_awvalid, axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        input  axi_bready, axi_arid, axi_araddr, axi_arlen, axi_arsize,
        input  axi_arburst, axi_arvalid, axi_rready,
        output axi_awready, axi_wready, axi_bid, axi_bresp, axi_bvalid,
        output axi_arready, axi_rid, axi_rdata, axi_rresp, axi_rlast,
        output axi_rvalid
    );

    modport master (
        output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst,
        output axi_awvalid, axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        output axi_bready, axi_arid, axi_araddr, axi_arlen, axi_arsize,
        output axi_arburst, axi_arvalid, axi_rready,
        input  axi_awready, axi_wready, axi_bid, axi_bresp, axi_bvalid,
        input  axi_arready, axi_rid, axi_rdata, axi_rresp, axi_rlast,
        input  axi_rvalid
    );
endinterface

// File: rtl/axi_mem_slave.sv
// AXI4 memory responder: word RAM, independent single-outstanding read/write engines.
// Define AXI_MEM_SLAVE_DECERR_EN to flag out-of-range beats with DECERR.
module axi_mem_slave #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    axi_mem_slave_if.slave  axi
);
    localparam int          IW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
`ifdef AXI_MEM_SLAVE_DECERR_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t    w_state, w_next;
    r_state_t    r_state, r_next;
    logic        up_q;
    logic [31:0] mem [DEPTH_WORDS];

    function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
        return IW'((a - BASE_ADDR) >> 2);
    endfunction

    function automatic logic in_range(input logic [31:0] a);
        logic [32:0] off;
        off = {1'b0, a} - {1'b0, BASE_ADDR};
        return (a >= BASE_ADDR) && (off < SPAN);
    endfunction

    function automatic logic [31:0] step(input logic [31:0] a,
                                         input logic [1:0]  burst);
        return (burst == 2'b00) ? a : a + 32'd4;
    endfunction

    logic        aw_rdy, w_rdy, b_vld, ar_rdy, r_vld;
    logic        aw_hs, w_hs, ar_hs, r_hs;
    logic [3:0]  w_id, r_id;
    logic [31:0] w_addr, r_addr;
    logic [7:0]  w_len, w_cnt, r_len, r_cnt;
    logic [1:0]  w_burst, r_burst;
    logic        w_size_err, w_err, w_dec, r_size_err;
    logic        w_dec_beat;
    logic [1:0]  b_resp;

    // up_q keeps both ready lines low until the first edge after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_q    <= 1'b0;
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            up_q    <= 1'b1;
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next = w_state;
        aw_rdy = 1'b0;
        w_rdy  = 1'b0;
        b_vld  = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                aw_rdy = up_q;
                if (axi.axi_awvalid && up_q) w_next = W_DATA;
            end
            W_DATA: begin
                w_rdy = 1'b1;
                if (axi.axi_wvalid && w_cnt == w_len) w_next = W_RESP;
            end
            W_RESP: begin
                b_vld = 1'b1;
                if (axi.axi_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next = r_state;
        ar_rdy = 1'b0;
        r_vld  = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                ar_rdy = up_q;
                if (axi.axi_arvalid && up_q) r_next = R_DATA;
            end
            R_DATA: begin
                r_vld = 1'b1;
                if (axi.axi_rready && r_cnt == r_len) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign aw_hs      = axi.axi_awvalid && aw_rdy;
    assign w_hs       = axi.axi_wvalid && w_rdy;
    assign ar_hs      = axi.axi_arvalid && ar_rdy;
    assign r_hs       = axi.axi_rready && r_vld;
    assign w_dec_beat = DEC_EN && !in_range(w_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_id       <= '0;
            w_addr     <= '0;
            w_len      <= '0;
            w_cnt      <= '0;
            w_burst    <= '0;
            w_size_err <= 1'b0;
            w_err      <= 1'b0;
            w_dec      <= 1'b0;
        end else if (aw_hs) begin
            w_id       <= axi.axi_awid;
            w_addr     <= axi.axi_awaddr;
            w_len      <= axi.axi_awlen;
            w_cnt      <= '0;
            w_burst    <= axi.axi_awburst;
            w_size_err <= axi.axi_awsize != 3'b010;
            w_err      <= 1'b0;
            w_dec      <= 1'b0;
        end else if (w_hs) begin
            w_cnt  <= w_cnt + 8'd1;
            w_addr <= step(w_addr, w_burst);
            if (axi.axi_wlast != (w_cnt == w_len)) w_err <= 1'b1;
            if (w_dec_beat) w_dec <= 1'b1;
        end
    end

    // RAM has no reset so contents survive a mid-burst reset
    always_ff @(posedge clk) begin
        if (w_hs && !w_dec_beat) begin
            for (int b = 0; b < 4; b++) begin
                if (axi.axi_wstrb[b])
                    mem[word_idx(w_addr)][8*b +: 8] <= axi.axi_wdata[8*b +: 8];
            end
        end
    end

    assign b_resp = w_dec ? 2'b11 : ((w_err || w_size_err) ? 2'b10 : 2'b00);

    logic [31:0] r_fetch;
    logic        r_load, r_fetch_serr, r_fetch_dec;
    logic [31:0] rd_word, r_data_q;
    logic [1:0]  r_resp_q;

    assign r_load       = ar_hs || (r_hs && r_cnt != r_len);
    assign r_fetch      = ar_hs ? axi.axi_araddr : step(r_addr, r_burst);
    assign r_fetch_serr = ar_hs ? (axi.axi_arsize != 3'b010) : r_size_err;
    assign r_fetch_dec  = DEC_EN && !in_range(r_fetch);

    // Bypass a same-edge write so the next beat sees the freshly written bytes
    always_comb begin
        rd_word = mem[word_idx(r_fetch)];
        if (w_hs && !w_dec_beat && word_idx(w_addr) == word_idx(r_fetch)) begin
            for (int b = 0; b < 4; b++) begin
                if (axi.axi_wstrb[b]) rd_word[8*b +: 8] = axi.axi_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id       <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_burst    <= '0;
            r_size_err <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= '0;
        end else begin
            if (ar_hs) begin
                r_id       <= axi.axi_arid;
                r_addr     <= axi.axi_araddr;
                r_len      <= axi.axi_arlen;
                r_cnt      <= '0;
                r_burst    <= axi.axi_arburst;
                r_size_err <= axi.axi_arsize != 3'b010;
            end else if (r_hs) begin
                r_cnt  <= r_cnt + 8'd1;
                r_addr <= r_fetch;
            end
            if (r_load) begin
                r_data_q <= r_fetch_dec ? 32'h0 : rd_word;
                r_resp_q <= r_fetch_dec ? 2'b11 : (r_fetch_serr ? 2'b10 : 2'b00);
            end
        end
    end

    assign axi.axi_awready = aw_rdy;
    assign axi.axi_wready  = w_rdy;
    assign axi.axi_bvalid  = b_vld;
    assign axi.axi_bid     = b_vld ? w_id : 4'h0;
    assign axi.axi_bresp   = b_vld ? b_resp : 2'b00;
    assign axi.axi_arready = ar_rdy;
    assign axi.axi_rvalid  = r_vld;
    assign axi.axi_rid     = r_id;
    assign axi.axi_rdata   = r_data_q;
    assign axi.axi_rresp   = r_resp_q;
    assign axi.axi_rlast   = r_vld && (r_cnt == r_len);
endmodule

// File: tb/tb_axi_mem_slave.sv
// Scoreboard bench for axi_mem_slave: expected B/R responses queued at stimulus time.
// Covers reset, bursts, strobes, wlast errors, back-pressure and mid-burst reset.
module tb_axi_mem_slave;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h8000_0000;
`ifdef AXI_MEM_SLAVE_DECERR_EN
    localparam bit DEC = 1'b1;
`else
    localparam bit DEC = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;
    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } bresp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] model [int];
    rbeat_t exp_r [$];
    rbeat_t obs_r [$];
    bresp_t exp_b [$];

    axi_mem_slave_if bus();

    axi_mem_slave #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .axi(bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int tb_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'((off >> 2) % DEPTH);
    endfunction

    function automatic bit tb_in_range(input logic [31:0] a);
        longint unsigned lo, hi;
        lo = BASE;
        hi = longint'(BASE) + 4 * DEPTH;
        return (longint'(a) >= lo) && (longint'(a) < hi);
    endfunction

    function automatic logic [31:0] tb_step(input logic [31:0] a, input logic [1:0] bu);
        return (bu == 2'b00) ? a : a + 32'd4;
    endfunction

    function automatic bresp_t tb_bresp(input logic [3:0] id, input logic [31:0] addr,
                                        input logic [7:0] len, input logic [1:0] bu,
                                        input logic [2:0] size, input int wlast_at);
        bresp_t  r;
        logic [31:0] a;
        bit      dec;
        a = addr;
        dec = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if (DEC && !tb_in_range(a)) dec = 1'b1;
            a = tb_step(a, bu);
        end
        r.id = id;
        if (dec) r.resp = 2'b11;
        else if (wlast_at != int'(len) || size != 3'b010) r.resp = 2'b10;
        else r.resp = 2'b00;
        return r;
    endfunction

    task automatic push_r(input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [1:0] bu, input logic [2:0] size);
        logic [31:0] a;
        rbeat_t e;
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            e.id = id;
            e.last = (i == int'(len));
            if (DEC && !tb_in_range(a)) begin
                e.data = 32'h0;
                e.resp = 2'b11;
            end else begin
                e.data = model[tb_idx(a)];
                e.resp = (size != 3'b010) ? 2'b10 : 2'b00;
            end
            exp_r.push_back(e);
            a = tb_step(a, bu);
        end
    endtask

    task automatic axi_aw_w(input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] bu, input logic [2:0] size,
                            input logic [31:0] dbase, input logic [3:0] strb, input int wlast_at);
        bit hs;
        int g;
        logic [31:0] a;
        int k;
        bus.axi_awid = id;
        bus.axi_awaddr = addr;
        bus.axi_awlen = len;
        bus.axi_awburst = bu;
        bus.axi_awsize = size;
        bus.axi_awvalid = 1'b1;
        g = 0;
        do begin
            hs = bus.axi_awready;
            tick();
            g++;
        end while (!hs && g < 100);
        bus.axi_awvalid = 1'b0;
        if (!hs) begin
            checks++;
            errors++;
            $display("FAIL aw_handshake timeout id=%0d", id);
        end
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            bus.axi_wvalid = 1'b1;
            bus.axi_wdata = dbase + 32'(i);
            bus.axi_wstrb = strb;
            bus.axi_wlast = (i == wlast_at);
            g = 0;
            do begin
                hs = bus.axi_wready;
                tick();
                g++;
            end while (!hs && g < 100);
            if (!hs) begin
                checks++;
                errors++;
                $display("FAIL w_handshake timeout beat=%0d", i);
            end else if (!(DEC && !tb_in_range(a))) begin
                k = tb_idx(a);
                if (!model.exists(k)) model[k] = 32'h0;
                for (int b = 0; b < 4; b++)
                    if (strb[b]) model[k][8*b +: 8] = bus.axi_wdata[8*b +: 8];
            end
            a = tb_step(a, bu);
        end
        bus.axi_wvalid = 1'b0;
        bus.axi_wlast = 1'b0;
    endtask

    task automatic axi_b(output bresp_t got);
        int g;
        bus.axi_bready = 1'b1;
        g = 0;
        while (!bus.axi_bvalid && g < 100) begin
            tick();
            g++;
        end
        if (!bus.axi_bvalid) begin
            checks++;
            errors++;
            $display("FAIL b_wait timeout");
        end
        got.id = bus.axi_bid;
        got.resp = bus.axi_bresp;
        tick();
        bus.axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] bu, input logic [2:0] size,
                            input bit toggle, output int lat, output int unstable,
                            output int cycles);
        bit hs, stall;
        int g, n;
        logic [40:0] snap;
        rbeat_t o;
        bus.axi_arid = id;
        bus.axi_araddr = addr;
        bus.axi_arlen = len;
        bus.axi_arburst = bu;
        bus.axi_arsize = size;
        bus.axi_arvalid = 1'b1;
        g = 0;
        do begin
            hs = bus.axi_arready;
            tick();
            g++;
        end while (!hs && g < 100);
        bus.axi_arvalid = 1'b0;
        if (!hs) begin
            checks++;
            errors++;
            $display("FAIL ar_handshake timeout id=%0d", id);
        end
        lat = 0;
        while (!bus.axi_rvalid && lat < 50) begin
            tick();
            lat++;
        end
        n = 0;
        cycles = 0;
        unstable = 0;
        while (n < int'(len) + 1 && cycles < 2000) begin
            bus.axi_rready = toggle ? (cycles % 2 == 1) : 1'b1;
            snap = {bus.axi_rvalid, bus.axi_rid, bus.axi_rdata, bus.axi_rresp,
                    bus.axi_rlast, 1'b0};
            stall = bus.axi_rvalid && !bus.axi_rready;
            if (bus.axi_rvalid && bus.axi_rready) begin
                o = {bus.axi_rid, bus.axi_rdata, bus.axi_rresp, bus.axi_rlast};
                obs_r.push_back(o);
                n++;
            end
            tick();
            cycles++;
            if (stall && snap !== {bus.axi_rvalid, bus.axi_rid, bus.axi_rdata,
                                   bus.axi_rresp, bus.axi_rlast, 1'b0})
                unstable++;
        end
        bus.axi_rready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({bus.axi_awready, bus.axi_wready, bus.axi_bvalid, bus.axi_bid, bus.axi_bresp,
             bus.axi_arready, bus.axi_rvalid, bus.axi_rid, bus.axi_rdata, bus.axi_rresp,
             bus.axi_rlast} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got nonzero awr=%b arr=%b rv=%b bv=%b want all 0",
                     bus.axi_awready, bus.axi_arready, bus.axi_rvalid, bus.axi_bvalid);
        end
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({bus.axi_awready, bus.axi_arready} !== 2'b00) begin
            errors++;
            $display("FAIL ready_before_edge got %b want 00", {bus.axi_awready, bus.axi_arready});
        end
        tick();
        checks++;
        if ({bus.axi_awready, bus.axi_arready} !== 2'b11) begin
            errors++;
            $display("FAIL ready_after_edge got %b want 11", {bus.axi_awready, bus.axi_arready});
        end
    endtask

    task automatic test_single();
        bresp_t gb, eb;
        rbeat_t e, o;
        int lat, uns, cyc;
        exp_b.push_back(tb_bresp(4'd3, BASE + 32'h10, 8'd0, 2'b01, 3'b010, 0));
        axi_aw_w(4'd3, BASE + 32'h10, 8'd0, 2'b01, 3'b010, 32'hDEAD_BEEF, 4'hF, 0);
        axi_b(gb);
        eb = exp_b.pop_front();
        checks++;
        if (gb !== eb) begin
            errors++;
            $display("FAIL single_b got id=%0d resp=%b want id=%0d resp=%b",
                     gb.id, gb.resp, eb.id, eb.resp);
        end
        push_r(4'd3, BASE + 32'h10, 8'd0, 2'b01, 3'b010);
        axi_read(4'd3, BASE + 32'h10, 8'd0, 2'b01, 3'b010, 1'b0, lat, uns, cyc);
        checks++;
        if (lat !== 0) begin
            errors++;
            $display("FAIL single_rvalid_latency got %0d want 0", lat);
        end
        checks++;
        if (obs_r.size() != exp_r.size()) begin
            errors++;
            $display("FAIL single_beats got %0d want %0d", obs_r.size(), exp_r.size());
        end
        while (obs_r.size() > 0 && exp_r.size() > 0) begin
            e = exp_r.pop_front();
            o = obs_r.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL single_r got %h want %h", o, e);
            end
        end
        exp_r.delete();
        obs_r.delete();
    endtask

    task automatic test_burst();
        bresp_t gb, eb;
        rbeat_t e, o;
        int lat, uns, cyc, n;
        exp_b.push_back(tb_bresp(4'd1, BASE + 32'h100, 8'd7, 2'b01, 3'b010, 7));
        axi_aw_w(4'd1, BASE + 32'h100, 8'd7, 2'b01, 3'b010, 32'h0, 4'hF, 7);
        axi_b(gb);
        eb = exp_b.pop_front();
        checks++;
        if (gb !== eb) begin
            errors++;
            $display("FAIL burst_b got id=%0d resp=%b want id=%0d resp=%b",
                     gb.id, gb.resp, eb.id, eb.resp);
        end
        push_r(4'd2, BASE + 32'h100, 8'd7, 2'b01, 3'b010);
        axi_read(4'd2, BASE + 32'h100, 8'd7, 2'b01, 3'b010, 1'b1, lat, uns, cyc);
        checks++;
        if (uns !== 0) begin
            errors++;
            $display("FAIL burst_stall_stable got %0d changes want 0", uns);
        end
        checks++;
        if (obs_r.size() != exp_r.size()) begin
            errors++;
            $display("FAIL burst_beats got %0d want %0d", obs_r.size(), exp_r.size());
        end
        n = 0;
        while (obs_r.size() > 0 && exp_r.size() > 0) begin
            e = exp_r.pop_front();
            o = obs_r.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL burst_r beat=%0d got %h want %h", n, o, e);
            end
            n++;
        end
        exp_r.delete();
        obs_r.delete();
        checks++;
        if (bus.axi_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL burst_extra_beat rvalid got %b want 0", bus.axi_rvalid);
        end
    endtask

    task automatic test_strobes();
        bresp_t gb, eb;
        rbeat_t e, o;
        int lat, uns, cyc;
        exp_b.push_back(tb_bresp(4'd4, BASE + 32'h180, 8'd0, 2'b01, 3'b010, 0));
        axi_aw_w(4'd4, BASE + 32'h180, 8'd0, 2'b01, 3'b010, 32'hFFFF_FFFF, 4'hF, 0);
        axi_b(gb);
        eb = exp_b.pop_front();
        exp_b.push_back(tb_bresp(4'd4, BASE + 32'h180, 8'd0, 2'b01, 3'b010, 0));
        axi_aw_w(4'd4, BASE + 32'h180, 8'd0, 2'b01, 3'b010, 32'h0, 4'b0101, 0);
        axi_b(gb);
        eb = exp_b.pop_front();
        checks++;
        if (gb !== eb) begin
            errors++;
            $display("FAIL strobe_b got resp=%b want %b", gb.resp, eb.resp);
        end
        push_r(4'd4, BASE + 32'h180, 8'd0, 2'b01, 3'b010);
        axi_read(4'd4, BASE + 32'h180, 8'd0, 2'b01, 3'b010, 1'b0, lat, uns, cyc);
        while (obs_r.size() > 0 && exp_r.size() > 0) begin
            e = exp_r.pop_front();
            o = obs_r.pop_front();
            checks++;
            if (o !== e || o.data !== 32'hFF00_FF00) begin
                errors++;
                $display("FAIL strobe_r got %h want data ff00ff00 beat %h", o, e);
            end
        end
        exp_r.delete();
        obs_r.delete();
    endtask

    task automatic test_wlast_err();
        bresp_t gb, eb;
        exp_b.push_back(tb_bresp(4'd7, BASE + 32'h200, 8'd3, 2'b01, 3'b010, 1));
        axi_aw_w(4'd7, BASE + 32'h200, 8'd3, 2'b01, 3'b010, 32'hA0, 4'hF, 1);
        axi_b(gb);
        eb = exp_b.pop_front();
        checks++;
        if (gb !== eb) begin
            errors++;
            $display("FAIL early_wlast got id=%0d resp=%b want id=%0d resp=%b",
                     gb.id, gb.resp, eb.id, eb.resp);
        end
        exp_b.push_back(tb_bresp(4'd8, BASE + 32'h240, 8'd2, 2'b01, 3'b010, -1));
        axi_aw_w(4'd8, BASE + 32'h240, 8'd2, 2'b01, 3'b010, 32'hB0, 4'hF, -1);
        axi_b(gb);
        eb = exp_b.pop_front();
        checks++;
        if (gb !== eb) begin
            errors++;
            $display("FAIL missing_wlast got resp=%b want %b", gb.resp, eb.resp);
        end
    endtask

    task automatic test_fixed_size();
        bresp_t gb, eb;
        rbeat_t e, o;
        int lat, uns, cyc;
        exp_b.push_back(tb_bresp(4'd9, BASE + 32'h300, 8'd2, 2'b00, 3'b010, 2));
        axi_aw_w(4'd9, BASE + 32'h300, 8'd2, 2'b00, 3'b010, 32'h50, 4'hF, 2);
        axi_b(gb);
        eb = exp_b.pop_front();
        exp_b.push_back(tb_bresp(4'd10, BASE + 32'h304, 8'd0, 2'b01, 3'b001, 0));
        axi_aw_w(4'd10, BASE + 32'h304, 8'd0, 2'b01, 3'b001, 32'h1234_5678, 4'hF, 0);
        axi_b(gb);
        eb = exp_b.pop_front();
        checks++;
        if (gb !== eb) begin
            errors++;
            $display("FAIL size_b got resp=%b want %b", gb.resp, eb.resp);
        end
        push_r(4'd9, BASE + 32'h300, 8'd1, 2'b00, 3'b010);
        axi_read(4'd9, BASE + 32'h300, 8'd1, 2'b00, 3'b010, 1'b0, lat, uns, cyc);
        push_r(4'd10, BASE + 32'h300, 8'd1, 2'b01, 3'b001);
        axi_read(4'd10, BASE + 32'h300, 8'd1, 2'b01, 3'b001, 1'b0, lat, uns, cyc);
        checks++;
        if (obs_r.size() != exp_r.size()) begin
            errors++;
            $display("FAIL fixed_beats got %0d want %0d", obs_r.size(), exp_r.size());
        end
        while (obs_r.size() > 0 && exp_r.size() > 0) begin
            e = exp_r.pop_front();
            o = obs_r.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL fixed_size_r got %h want %h", o, e);
            end
        end
        exp_r.delete();
        obs_r.delete();
    endtask

    task automatic test_b_backpressure();
        bresp_t gb, eb;
        logic [5:0] snap;
        axi_aw_w(4'd5, BASE + 32'h400, 8'd0, 2'b01, 3'b010, 32'h5555_0000, 4'hF, 0);
        exp_b.push_back(tb_bresp(4'd5, BASE + 32'h400, 8'd0, 2'b01, 3'b010, 0));
        snap = {bus.axi_bid, bus.axi_bresp};
        bus.axi_awid = 4'd6;
        bus.axi_awaddr = BASE + 32'h404;
        bus.axi_awlen = 8'd0;
        bus.axi_awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.axi_bvalid !== 1'b1 || {bus.axi_bid, bus.axi_bresp} !== snap ||
                bus.axi_awready !== 1'b0) begin
                errors++;
                $display("FAIL b_hold cyc=%0d got bv=%b b=%h awr=%b want 1 %h 0",
                         i, bus.axi_bvalid, {bus.axi_bid, bus.axi_bresp}, snap,
                         bus.axi_awready);
            end
            tick();
        end
        axi_b(gb);
        eb = exp_b.pop_front();
        checks++;
        if (gb !== eb) begin
            errors++;
            $display("FAIL b_hold_resp got id=%0d resp=%b want id=%0d resp=%b",
                     gb.id, gb.resp, eb.id, eb.resp);
        end
        checks++;
        if (bus.axi_awready !== 1'b1) begin
            errors++;
            $display("FAIL aw_after_b got awready=%b want 1", bus.axi_awready);
        end
        exp_b.push_back(tb_bresp(4'd6, BASE + 32'h404, 8'd0, 2'b01, 3'b010, 0));
        axi_aw_w(4'd6, BASE + 32'h404, 8'd0, 2'b01, 3'b010, 32'h6666_0000, 4'hF, 0);
        axi_b(gb);
        eb = exp_b.pop_front();
        checks++;
        if (gb !== eb) begin
            errors++;
            $display("FAIL pending_aw_b got id=%0d resp=%b want id=%0d resp=%b",
                     gb.id, gb.resp, eb.id, eb.resp);
        end
    endtask

    task automatic test_reset_mid_burst();
        rbeat_t e, o;
        int lat, uns, cyc;
        bus.axi_arid = 4'd11;
        bus.axi_araddr = BASE + 32'h100;
        bus.axi_arlen = 8'd7;
        bus.axi_arburst = 2'b01;
        bus.axi_arsize = 3'b010;
        bus.axi_arvalid = 1'b1;
        tick();
        bus.axi_arvalid = 1'b0;
        bus.axi_rready = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.axi_rvalid !== 1'b1 || bus.axi_rdata !== model[tb_idx(BASE + 32'h108)]) begin
            errors++;
            $display("FAIL mid_beat2 got rv=%b data=%h want 1 %h", bus.axi_rvalid,
                     bus.axi_rdata, model[tb_idx(BASE + 32'h108)]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.axi_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_rvalid got %b want 0", bus.axi_rvalid);
        end
        bus.axi_rready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.axi_arready !== 1'b1) begin
            errors++;
            $display("FAIL arready_after_release got %b want 1", bus.axi_arready);
        end
        push_r(4'd12, BASE + 32'h100, 8'd7, 2'b01, 3'b010);
        axi_read(4'd12, BASE + 32'h100, 8'd7, 2'b01, 3'b010, 1'b0, lat, uns, cyc);
        checks++;
        if (cyc !== 8) begin
            errors++;
            $display("FAIL no_bubble_cycles got %0d want 8", cyc);
        end
        checks++;
        if (obs_r.size() != exp_r.size()) begin
            errors++;
            $display("FAIL retained_beats got %0d want %0d", obs_r.size(), exp_r.size());
        end
        while (obs_r.size() > 0 && exp_r.size() > 0) begin
            e = exp_r.pop_front();
            o = obs_r.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL retained_r got %h want %h", o, e);
            end
        end
        exp_r.delete();
        obs_r.delete();
    endtask

    task automatic test_range();
        bresp_t gb, eb;
        rbeat_t e, o;
        int lat, uns, cyc;
        logic [31:0] edge_a;
        edge_a = BASE + 32'(4 * DEPTH) - 32'd4;
        exp_b.push_back(tb_bresp(4'd13, edge_a, 8'd1, 2'b01, 3'b010, 1));
        axi_aw_w(4'd13, edge_a, 8'd1, 2'b01, 3'b010, 32'hC0DE_0000, 4'hF, 1);
        axi_b(gb);
        eb = exp_b.pop_front();
        checks++;
        if (gb !== eb) begin
            errors++;
            $display("FAIL range_b got resp=%b want %b", gb.resp, eb.resp);
        end
        push_r(4'd13, edge_a, 8'd1, 2'b01, 3'b010);
        axi_read(4'd13, edge_a, 8'd1, 2'b01, 3'b010, 1'b0, lat, uns, cyc);
        push_r(4'd14, BASE + 32'h10, 8'd0, 2'b01, 3'b010);
        axi_read(4'd14, BASE + 32'h10, 8'd0, 2'b01, 3'b010, 1'b0, lat, uns, cyc);
        checks++;
        if (obs_r.size() != exp_r.size()) begin
            errors++;
            $display("FAIL range_beats got %0d want %0d", obs_r.size(), exp_r.size());
        end
        while (obs_r.size() > 0 && exp_r.size() > 0) begin
            e = exp_r.pop_front();
            o = obs_r.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL range_r got %h want %h", o, e);
            end
        end
        exp_r.delete();
        obs_r.delete();
    endtask

    initial begin
        bus.axi_awid = '0;
        bus.axi_awaddr = '0;
        bus.axi_awlen = '0;
        bus.axi_awsize = 3'b010;
        bus.axi_awburst = 2'b01;
        bus.axi_awvalid = 1'b0;
        bus.axi_wdata = '0;
        bus.axi_wstrb = '0;
        bus.axi_wlast = 1'b0;
        bus.axi_wvalid = 1'b0;
        bus.axi_bready = 1'b0;
        bus.axi_arid = '0;
        bus.axi_araddr = '0;
        bus.axi_arlen = '0;
        bus.axi_arsize = 3'b010;
        bus.axi_arburst = 2'b01;
        bus.axi_arvalid = 1'b0;
        bus.axi_rready = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_strobes();
        test_wlast_err();
        test_fixed_size();
        test_b_backpressure();
        test_reset_mid_burst();
        test_range();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
